ex_stage: RTL and testbench



---
 rtl/ex_stage_if.sv | 40 ++++
 rtl/ex_stage.sv | 169 ++++++++++++++++
 tb/tb_ex_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Execute-stage bus: instruction fields from ID/EX going in, MEM-stage
// results and the front-end redirect coming out.
interface ex_stage_if;
  logic [31:0] reg1_in;
  logic [31:0] reg2_in;
  logic [4:0]  rsd_in;
  logic        write_rsd_or_not_in;
  logic [5:0]  cmdtype_in;
  logic [31:0] pc_in;
  logic [31:0] imm_in;
  logic        stall_in;

  logic [31:0] result_out;
  logic [31:0] mem_addr_out;
  logic [31:0] store_data_out;
  logic [4:0]  rsd_out;
  logic        write_rsd_or_not_out;
  logic [5:0]  cmdtype_out;
  logic        valid_out;
  logic        jump_flag_out;
  logic [31:0] jump_pc_out;

  // Upstream side: presents instructions and observes results.
  modport master (
    output reg1_in, reg2_in, rsd_in, write_rsd_or_not_in, cmdtype_in,
           pc_in, imm_in, stall_in,
    input  result_out, mem_addr_out, store_data_out, rsd_out,
           write_rsd_or_not_out, cmdtype_out, valid_out, jump_flag_out,
           jump_pc_out
  );

  // Execute stage side.
  modport slave (
    input  reg1_in, reg2_in, rsd_in, write_rsd_or_not_in, cmdtype_in,
           pc_in, imm_in, stall_in,
    output result_out, mem_addr_out, store_data_out, rsd_out,
           write_rsd_or_not_out, cmdtype_out, valid_out, jump_flag_out,
           jump_pc_out
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, address generation, branch/jump resolution,
// one-cycle registered output toward MEM, and wrong-path squashing.
module ex_stage #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  ex_stage_if.slave  bus
);
  localparam logic [5:0] CMD_NOP   = 6'd0,  CMD_ADD   = 6'd1,  CMD_ADDI  = 6'd2,
                         CMD_SUB   = 6'd3,  CMD_SLT   = 6'd4,  CMD_SLTI  = 6'd5,
                         CMD_SLTU  = 6'd6,  CMD_SLTIU = 6'd7,  CMD_AND   = 6'd8,
                         CMD_ANDI  = 6'd9,  CMD_OR    = 6'd10, CMD_ORI   = 6'd11,
                         CMD_XOR   = 6'd12, CMD_XORI  = 6'd13, CMD_SLL   = 6'd14,
                         CMD_SLLI  = 6'd15, CMD_SRL   = 6'd16, CMD_SRLI  = 6'd17,
                         CMD_SRA   = 6'd18, CMD_SRAI  = 6'd19, CMD_LUI   = 6'd20,
                         CMD_AUIPC = 6'd21, CMD_JAL   = 6'd22, CMD_JALR  = 6'd23,
                         CMD_BEQ   = 6'd24, CMD_BNE   = 6'd25, CMD_BLT   = 6'd26,
                         CMD_BGE   = 6'd27, CMD_BLTU  = 6'd28, CMD_BGEU  = 6'd29,
                         CMD_LB    = 6'd30, CMD_LH    = 6'd31, CMD_LW    = 6'd32,
                         CMD_LBU   = 6'd33, CMD_LHU   = 6'd34, CMD_SB    = 6'd35,
                         CMD_SH    = 6'd36, CMD_SW    = 6'd37;

  localparam int CNT_W = $clog2(SQUASH_DEPTH + 2);
  localparam logic [CNT_W-1:0] SQUASH_LOAD = CNT_W'(SQUASH_DEPTH);

  logic [31:0] result_d, result_q, mem_addr_d, mem_addr_q;
  logic [31:0] store_data_d, store_data_q, jump_pc_d, jump_pc_q;
  logic [4:0]  rsd_d, rsd_q;
  logic        write_rsd_d, write_rsd_q, valid_d, valid_q, jump_flag_d, jump_flag_q;
  logic [5:0]  cmdtype_d, cmdtype_q;
  logic [CNT_W-1:0] squash_cnt_d, squash_cnt_q;

  logic [31:0] op2, ex_result, ex_addr, ex_store, ex_target;
  logic        ex_redirect, ex_writes, uses_imm;

  // Combinational execute: result, address, store data and redirect decision.
  always_comb begin
    ex_result   = '0;
    ex_addr     = '0;
    ex_store    = '0;
    ex_target   = '0;
    ex_redirect = 1'b0;
    ex_writes   = 1'b1;
    uses_imm    = (bus.cmdtype_in inside {CMD_ADDI, CMD_SLTI, CMD_SLTIU, CMD_ANDI,
                                          CMD_ORI, CMD_XORI, CMD_SLLI, CMD_SRLI, CMD_SRAI});
    op2         = uses_imm ? bus.imm_in : bus.reg2_in;
    case (bus.cmdtype_in)
      CMD_ADD, CMD_ADDI:    ex_result = bus.reg1_in + op2;
      CMD_SUB:              ex_result = bus.reg1_in - bus.reg2_in;
      CMD_SLT, CMD_SLTI:    ex_result = {31'd0, $signed(bus.reg1_in) < $signed(op2)};
      CMD_SLTU, CMD_SLTIU:  ex_result = {31'd0, bus.reg1_in < op2};
      CMD_AND, CMD_ANDI:    ex_result = bus.reg1_in & op2;
      CMD_OR, CMD_ORI:      ex_result = bus.reg1_in | op2;
      CMD_XOR, CMD_XORI:    ex_result = bus.reg1_in ^ op2;
      CMD_SLL, CMD_SLLI:    ex_result = bus.reg1_in << op2[4:0];
      CMD_SRL, CMD_SRLI:    ex_result = bus.reg1_in >> op2[4:0];
      CMD_SRA, CMD_SRAI:    ex_result = $unsigned($signed(bus.reg1_in) >>> op2[4:0]);
      CMD_LUI:              ex_result = bus.imm_in;
      CMD_AUIPC:            ex_result = bus.pc_in + bus.imm_in;
      CMD_JAL: begin
        ex_result   = bus.pc_in + 32'd4;
        ex_target   = bus.pc_in + bus.imm_in;
        ex_redirect = 1'b1;
      end
      CMD_JALR: begin
        ex_result   = bus.pc_in + 32'd4;
        ex_target   = (bus.reg1_in + bus.imm_in) & ~32'h1;
        ex_redirect = 1'b1;
      end
      CMD_BEQ, CMD_BNE, CMD_BLT, CMD_BGE, CMD_BLTU, CMD_BGEU: begin
        ex_writes = 1'b0;
        ex_target = bus.pc_in + bus.imm_in;
        case (bus.cmdtype_in)
          CMD_BEQ:  ex_redirect = (bus.reg1_in == bus.reg2_in);
          CMD_BNE:  ex_redirect = (bus.reg1_in != bus.reg2_in);
          CMD_BLT:  ex_redirect = ($signed(bus.reg1_in) <  $signed(bus.reg2_in));
          CMD_BGE:  ex_redirect = ($signed(bus.reg1_in) >= $signed(bus.reg2_in));
          CMD_BLTU: ex_redirect = (bus.reg1_in <  bus.reg2_in);
          default:  ex_redirect = (bus.reg1_in >= bus.reg2_in);
        endcase
        if (!ex_redirect) ex_target = '0;
      end
      CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU:
        ex_addr = bus.reg1_in + bus.imm_in;
      CMD_SB, CMD_SH, CMD_SW: begin
        ex_writes = 1'b0;
        ex_addr   = bus.reg1_in + bus.imm_in;
        ex_store  = bus.reg2_in;
      end
      default: ex_result = '0;
    endcase
  end

  // Next-state: hold on stall, drop wrong-path slots, otherwise load new results.
  always_comb begin
    result_d     = result_q;
    mem_addr_d   = mem_addr_q;
    store_data_d = store_data_q;
    jump_pc_d    = jump_pc_q;
    rsd_d        = rsd_q;
    write_rsd_d  = write_rsd_q;
    valid_d      = valid_q;
    cmdtype_d    = cmdtype_q;
    squash_cnt_d = squash_cnt_q;
    jump_flag_d  = 1'b0;
    if (!bus.stall_in) begin
      result_d     = '0;
      mem_addr_d   = '0;
      store_data_d = '0;
      jump_pc_d    = '0;
      rsd_d        = '0;
      write_rsd_d  = 1'b0;
      valid_d      = 1'b0;
      cmdtype_d    = CMD_NOP;
      if (squash_cnt_q != '0) begin
        squash_cnt_d = squash_cnt_q - 1'b1;
      end else if (bus.cmdtype_in != CMD_NOP) begin
        result_d     = ex_result;
        mem_addr_d   = ex_addr;
        store_data_d = ex_store;
        jump_pc_d    = ex_target;
        rsd_d        = ex_writes ? bus.rsd_in : 5'd0;
        write_rsd_d  = ex_writes && bus.write_rsd_or_not_in && (bus.rsd_in != 5'd0);
        valid_d      = 1'b1;
        cmdtype_d    = bus.cmdtype_in;
        jump_flag_d  = ex_redirect;
        if (ex_redirect) squash_cnt_d = SQUASH_LOAD;
      end
    end
  end

  // Output register toward MEM; reset clears everything including the squash counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      result_q     <= '0;
      mem_addr_q   <= '0;
      store_data_q <= '0;
      jump_pc_q    <= '0;
      rsd_q        <= '0;
      write_rsd_q  <= 1'b0;
      valid_q      <= 1'b0;
      cmdtype_q    <= '0;
      jump_flag_q  <= 1'b0;
      squash_cnt_q <= '0;
    end else begin
      result_q     <= result_d;
      mem_addr_q   <= mem_addr_d;
      store_data_q <= store_data_d;
      jump_pc_q    <= jump_pc_d;
      rsd_q        <= rsd_d;
      write_rsd_q  <= write_rsd_d;
      valid_q      <= valid_d;
      cmdtype_q    <= cmdtype_d;
      jump_flag_q  <= jump_flag_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign bus.result_out           = result_q;
  assign bus.mem_addr_out         = mem_addr_q;
  assign bus.store_data_out       = store_data_q;
  assign bus.jump_pc_out          = jump_pc_q;
  assign bus.rsd_out              = rsd_q;
  assign bus.write_rsd_or_not_out = write_rsd_q;
  assign bus.valid_out            = valid_q;
  assign bus.cmdtype_out          = cmdtype_q;
  assign bus.jump_flag_out        = jump_flag_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, jumps/branches, squash, stall, reset.
module tb_ex_stage;
  localparam logic [5:0] C_ADD = 6'd1, C_ADDI = 6'd2, C_SUB = 6'd3, C_SLTU = 6'd6,
                         C_SRA = 6'd18, C_JAL = 6'd22, C_JALR = 6'd23, C_BNE = 6'd25,
                         C_BLT = 6'd26, C_LW = 6'd32, C_SW = 6'd37;

  logic clk_in = 1'b0;
  logic rst_in;
  int   n_checks = 0;
  int   n_errors = 0;

  ex_stage_if bus ();

  ex_stage #(.SQUASH_DEPTH(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction for one clock edge, then sample 1 time unit later.
  task automatic issue(input logic [5:0] cmd, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rsd,
                       input logic stall);
    bus.cmdtype_in          = cmd;
    bus.reg1_in             = r1;
    bus.reg2_in             = r2;
    bus.imm_in              = imm;
    bus.pc_in               = pc;
    bus.rsd_in              = rsd;
    bus.write_rsd_or_not_in = 1'b1;
    bus.stall_in            = stall;
    @(posedge clk_in);
    #1;
    $display("txn cmd=%0d r1=%h r2=%h imm=%h pc=%h rsd=%0d stall=%0b -> res=%h v=%0b jf=%0b jpc=%h",
             cmd, r1, r2, imm, pc, rsd, stall, bus.result_out, bus.valid_out,
             bus.jump_flag_out, bus.jump_pc_out);
  endtask

  initial begin
    // Reset with random inputs
    rst_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.cmdtype_in          = 6'($urandom_range(1, 37));
      bus.reg1_in             = $urandom;
      bus.reg2_in             = $urandom;
      bus.imm_in              = $urandom;
      bus.pc_in               = $urandom;
      bus.rsd_in              = 5'($urandom);
      bus.write_rsd_or_not_in = 1'b1;
      bus.stall_in            = 1'($urandom);
      @(posedge clk_in);
      #1;
    end
    check("rst_result", bus.result_out, 32'h0);
    check("rst_valid", {31'd0, bus.valid_out}, 32'h0);
    check("rst_jflag", {31'd0, bus.jump_flag_out}, 32'h0);
    check("rst_jpc", bus.jump_pc_out, 32'h0);
    check("rst_wr", {31'd0, bus.write_rsd_or_not_out}, 32'h0);
    check("rst_rsd", {27'd0, bus.rsd_out}, 32'h0);
    check("rst_cmd", {26'd0, bus.cmdtype_out}, 32'h0);
    check("rst_addr", bus.mem_addr_out, 32'h0);
    check("rst_sdata", bus.store_data_out, 32'h0);
    rst_in = 1'b0;

    // ALU
    issue(C_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd5, 1'b0);
    check("add_res", bus.result_out, 32'h0);
    check("add_rsd", {27'd0, bus.rsd_out}, 32'd5);
    check("add_wr", {31'd0, bus.write_rsd_or_not_out}, 32'h1);
    check("add_valid", {31'd0, bus.valid_out}, 32'h1);
    check("add_cmd", {26'd0, bus.cmdtype_out}, {26'd0, C_ADD});
    issue(C_SRA, 32'h80000000, 32'h21, 32'h0, 32'h0, 5'd6, 1'b0);
    check("sra_res", bus.result_out, 32'hC0000000);
    issue(C_SLTU, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd7, 1'b0);
    check("sltu_res", bus.result_out, 32'h1);
    issue(C_SUB, 32'h5, 32'h7, 32'h0, 32'h0, 5'd8, 1'b0);
    check("sub_res", bus.result_out, 32'hFFFFFFFE);

    // JALR redirect and squash of the next two accepted instructions
    issue(C_JALR, 32'h203, 32'h0, 32'h4, 32'h100, 5'd1, 1'b0);
    check("jalr_jf", {31'd0, bus.jump_flag_out}, 32'h1);
    check("jalr_jpc", bus.jump_pc_out, 32'h206);
    check("jalr_res", bus.result_out, 32'h104);
    issue(C_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 5'd3, 1'b0);
    check("sq1_jf", {31'd0, bus.jump_flag_out}, 32'h0);
    check("sq1_valid", {31'd0, bus.valid_out}, 32'h0);
    check("sq1_wr", {31'd0, bus.write_rsd_or_not_out}, 32'h0);
    issue(C_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 5'd3, 1'b0);
    check("sq2_valid", {31'd0, bus.valid_out}, 32'h0);
    issue(C_ADD, 32'h10, 32'h20, 32'h0, 32'h0, 5'd3, 1'b0);
    check("post_sq_valid", {31'd0, bus.valid_out}, 32'h1);
    check("post_sq_res", bus.result_out, 32'h30);

    // Stall holds outputs while inputs change
    issue(C_ADD, 32'h7, 32'h8, 32'h0, 32'h0, 5'd4, 1'b0);
    check("pre_stall_res", bus.result_out, 32'd15);
    for (int i = 0; i < 3; i++) begin
      issue(C_ADD, 32'd100 + 32'(i), 32'd200, 32'h0, 32'h0, 5'd9, 1'b1);
      check("stall_res", bus.result_out, 32'd15);
      check("stall_rsd", {27'd0, bus.rsd_out}, 32'd4);
      check("stall_valid", {31'd0, bus.valid_out}, 32'h1);
    end
    issue(C_ADD, 32'd100, 32'd200, 32'h0, 32'h0, 5'd6, 1'b0);
    check("release_res", bus.result_out, 32'd300);
    check("release_rsd", {27'd0, bus.rsd_out}, 32'd6);

    // Jump presented under stall: no redirect until accepted
    issue(C_JAL, 32'h0, 32'h0, 32'h10, 32'h200, 5'd1, 1'b1);
    check("stalljal_jf", {31'd0, bus.jump_flag_out}, 32'h0);
    check("stalljal_res", bus.result_out, 32'd300);
    issue(C_JAL, 32'h0, 32'h0, 32'h10, 32'h200, 5'd1, 1'b0);
    check("jal_jf", {31'd0, bus.jump_flag_out}, 32'h1);
    check("jal_jpc", bus.jump_pc_out, 32'h210);
    check("jal_res", bus.result_out, 32'h204);
    issue(C_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 5'd2, 1'b1);
    check("pulse_once", {31'd0, bus.jump_flag_out}, 32'h0);
    check("pulse_hold_res", bus.result_out, 32'h204);
    // Squashed JAL must not reload the counter
    issue(C_JAL, 32'h0, 32'h0, 32'h40, 32'h300, 5'd1, 1'b0);
    check("sqjal_jf", {31'd0, bus.jump_flag_out}, 32'h0);
    check("sqjal_valid", {31'd0, bus.valid_out}, 32'h0);
    issue(C_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 5'd2, 1'b0);
    check("sqadd_valid", {31'd0, bus.valid_out}, 32'h0);
    issue(C_ADD, 32'h3, 32'h4, 32'h0, 32'h0, 5'd2, 1'b0);
    check("noreload_valid", {31'd0, bus.valid_out}, 32'h1);
    check("noreload_res", bus.result_out, 32'h7);

    // Branches
    issue(C_BNE, 32'h5, 32'h5, 32'h20, 32'h80, 5'd0, 1'b0);
    check("bne_jf", {31'd0, bus.jump_flag_out}, 32'h0);
    check("bne_wr", {31'd0, bus.write_rsd_or_not_out}, 32'h0);
    issue(C_ADD, 32'h2, 32'h2, 32'h0, 32'h0, 5'd3, 1'b0);
    check("bne_nosq_valid", {31'd0, bus.valid_out}, 32'h1);
    issue(C_BLT, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFF0, 32'h40, 5'd0, 1'b0);
    check("blt_jf", {31'd0, bus.jump_flag_out}, 32'h1);
    check("blt_jpc", bus.jump_pc_out, 32'h30);

    // Reset with one squash slot pending
    issue(C_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 5'd3, 1'b0);
    check("blt_sq_valid", {31'd0, bus.valid_out}, 32'h0);
    rst_in = 1'b1;
    issue(C_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 5'd3, 1'b0);
    check("midrst_valid", {31'd0, bus.valid_out}, 32'h0);
    rst_in = 1'b0;
    issue(C_ADD, 32'h9, 32'h1, 32'h0, 32'h0, 5'd3, 1'b0);
    check("after_rst_valid", {31'd0, bus.valid_out}, 32'h1);
    check("after_rst_res", bus.result_out, 32'hA);

    // rsd=0 suppresses the write; load/store addressing
    issue(C_ADDI, 32'h10, 32'h0, 32'h5, 32'h0, 5'd0, 1'b0);
    check("addi_x0_wr", {31'd0, bus.write_rsd_or_not_out}, 32'h0);
    check("addi_x0_res", bus.result_out, 32'h15);
    issue(C_LW, 32'h1000, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd10, 1'b0);
    check("lw_addr", bus.mem_addr_out, 32'hFFC);
    check("lw_wr", {31'd0, bus.write_rsd_or_not_out}, 32'h1);
    issue(C_SW, 32'h2000, 32'hDEADBEEF, 32'h8, 32'h0, 5'd0, 1'b0);
    check("sw_addr", bus.mem_addr_out, 32'h2008);
    check("sw_data", bus.store_data_out, 32'hDEADBEEF);
    check("sw_wr", {31'd0, bus.write_rsd_or_not_out}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
